rx_bit_decoder: RTL
===================

# rx_bit_decoder

USB full-speed receive front end that recovers bit timing from the synchronized D+/D- line pair, NRZI-decodes, removes stuffed bits and detects end-of-packet. Its decoded bit and one-cycle strobe feed `shift_register` (`d_orig`, `shift_enable`) directly. Its byte, EOP and error pulses feed the RX control FSM.

## Interface
- `CLKS_PER_BIT`, 8: system clocks per USB bit time (≥4, even).
- `SAMPLE_PT`, 3: value of the bit-phase counter at which the line is sampled (< `CLKS_PER_BIT`).
- `clk` in 1: system clock.
- `n_rst` in 1: asynchronous, active-low reset.
- `d_plus_sync` in 1: D+ already synchronized to `clk`.
- `d_minus_sync` in 1: D- already synchronized to `clk`.
- `d_orig` out 1: decoded (NRZI-removed, unstuffed) data bit; valid when `shift_enable`=1.
- `shift_enable` out 1: one-cycle strobe per accepted data bit.
- `byte_received` out 1: one-cycle pulse after every 8th accepted bit.
- `eop` out 1: one-cycle pulse on detected SE0 end-of-packet.
- `align_err` out 1: pulses together with `eop` if the bit count is not a byte multiple.
- `stuff_err` out 1: one-cycle pulse when a stuffed bit position holds a 1.

## Operation
- Registers:
  - `dp_q`: previous `d_plus_sync`.
  - `prev_line`: line level at the last sample.
  - `cnt` (bit phase, 0..`CLKS_PER_BIT`-1).
  - `ones_cnt` (0..6).
  - `bit_cnt` (0..7).
  - `state`.
- States:
  - IDLE: waits for start of packet.
  - ACTIVE: decodes bits.
  - ERR: suppresses output after a stuff error.
  - EOP_WAIT: waits for the line to return to idle.
- Edge detect: `edge` = `d_plus_sync` != `dp_q`.
- Phase counter:
  - In ACTIVE/ERR, an `edge` forces `cnt`←0.
  - Otherwise `cnt` increments, wrapping `CLKS_PER_BIT`-1→0.
  - Sample strobe `samp` = (`cnt`==`SAMPLE_PT`), in ACTIVE/ERR/EOP_WAIT only.
- IDLE→ACTIVE on `dp_q`=1 and `d_plus_sync`=0 (J→K). On entry: `cnt`←0, `prev_line`←1, `ones_cnt`←0, `bit_cnt`←0.
- ACTIVE, at `samp`, priority order:
  - SE0 (`d_plus_sync`=0 and `d_minus_sync`=0): `eop` pulse; `align_err` pulse if `bit_cnt`≠0; go to EOP_WAIT. No shift for this sample.
  - Otherwise compute `bit` = (`d_plus_sync`==`prev_line`), then `prev_line`←`d_plus_sync`.
  - If `ones_cnt`==6 and `bit`=0: stuffed bit. Drop it (no `shift_enable`); `ones_cnt`←0.
  - If `ones_cnt`==6 and `bit`=1: `stuff_err` pulse; go to ERR.
  - Else accept the bit:
    - `shift_enable` pulse with `d_orig`=`bit`.
    - `ones_cnt`←`bit` ? `ones_cnt`+1 : 0.
    - `bit_cnt`←`bit_cnt`+1 mod 8.
    - On the 7→0 wrap, pulse `byte_received`.
- ERR: no `shift_enable`/`byte_received`. SE0 at `samp` → `eop` pulse (`align_err` suppressed) and go to EOP_WAIT.
- EOP_WAIT: at `samp` with `d_plus_sync`=1 and `d_minus_sync`=0 (J) → IDLE. SE0 samples there produce no further `eop`.
- Counters saturate or wrap only as stated; `ones_cnt` never exceeds 6.

## Timing
- Every output is registered. Reset value of all outputs is 0. On reset: state IDLE, `prev_line`=1, all counters 0, `dp_q`=1.
- Reset asserted mid-packet aborts immediately; no pulse is emitted on reset release.
- Edge seen in cycle E → `cnt`=0 in E+1 → sample in E+1+`SAMPLE_PT` (E+4 at defaults).
- A decision made in sample cycle S drives `shift_enable`/`d_orig`, `eop`, `align_err` and `stuff_err` high during S+1, for exactly one cycle.
- `byte_received` is high in S+2, one cycle after the 8th `shift_enable`, so the downstream register already holds the full byte.
- `d_orig` holds its last value between strobes.
- Without edges, samples repeat every `CLKS_PER_BIT` cycles. An edge arriving at any phase, including the sample cycle itself, resynchronizes: `cnt`←0 takes priority over the strobe of the following cycle.
- At most one of `shift_enable`/`stuff_err`/`eop` is asserted per sample.

## Test plan
- SYNC: idle J, then line K J K J K J K K at 8 clk/bit → 8 `shift_enable` with bits 0,0,0,0,0,0,0,1; `byte_received` once. `shift_register` then holds 0x80.
- Stuffing: after SYNC, byte 0xFF sent LSB-first with a stuffed 0 after the 6th one (9 line bits) → exactly 8 `shift_enable`, all `d_orig`=1, one `byte_received`, no `stuff_err`.
- Stuff error: seven consecutive decoded 1s → 6 strobes, `stuff_err` at the 7th sample+1, no further strobes. SE0 then gives `eop` with `align_err`=0, then return to IDLE after J.
- EOP: SYNC + 0xA5, then 2 bit-times SE0 then J → 16 strobes, 2 `byte_received`, a single `eop`, `align_err`=0. The same with 3 extra bits → `eop` with `align_err`=1.
- Drift: bit periods of 7 and 9 clocks alternating across SYNC + 0x3C → identical decoded bits to the nominal case.
- Reset mid-byte: assert `n_rst` after 4 strobes → all outputs 0 at once. After release, a fresh SYNC decodes correctly with `bit_cnt` restarting from 0.

Source files
------------

// File: rtl/rx_bit_decoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rx_bit_decoder_if
// Brief    : Line inputs and decoded-bit/event outputs of the USB RX front end
// Revision : 1.0
// ============================================================================
interface rx_bit_decoder_if;
    logic d_plus_sync;
    logic d_minus_sync;
    logic d_orig;
    logic shift_enable;
    logic byte_received;
    logic eop;
    logic align_err;
    logic stuff_err;

    // master drives the line, slave is the decoder
    modport master (
        output d_plus_sync, d_minus_sync,
        input  d_orig, shift_enable, byte_received, eop, align_err, stuff_err
    );
    modport slave (
        input  d_plus_sync, d_minus_sync,
        output d_orig, shift_enable, byte_received, eop, align_err, stuff_err
    );
endinterface
`default_nettype wire

// File: rtl/rx_bit_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rx_bit_decoder
// Brief    : USB FS RX bit recovery, NRZI decode, bit unstuffing and EOP detect
// Revision : 1.0
// ============================================================================
module rx_bit_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PT    = 3
) (
    input wire clk,
    input wire n_rst,
    rx_bit_decoder_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_SAMPLE_PT = CW'(SAMPLE_PT);
    localparam logic [CW-1:0] C_LAST_PH   = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACTIVE   = 2'd1;
    localparam logic [1:0] S_ERR      = 2'd2;
    localparam logic [1:0] S_EOP_WAIT = 2'd3;

    logic [1:0]    state, state_nxt;
    logic          dp_q;
    logic          prev_line, prev_line_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    ones_cnt, ones_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic          byte_wrap, byte_wrap_nxt;
    logic          d_orig_q, d_orig_nxt;
    logic          shift_q, shift_nxt;
    logic          byte_q;
    logic          eop_q, eop_nxt;
    logic          align_q, align_nxt;
    logic          stuff_q, stuff_nxt;

    logic line_edge, samp, se0, line_j, start, bit_val;

    assign line_edge = bus.d_plus_sync != dp_q;
    assign se0       = !bus.d_plus_sync && !bus.d_minus_sync;
    assign line_j    = bus.d_plus_sync && !bus.d_minus_sync;
    assign start     = (state == S_IDLE) && dp_q && !bus.d_plus_sync;
    assign samp      = (cnt == C_SAMPLE_PT) && (state != S_IDLE);
    assign bit_val   = bus.d_plus_sync == prev_line;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= S_IDLE;
            dp_q      <= 1'b1;
            prev_line <= 1'b1;
            cnt       <= '0;
            ones_cnt  <= 3'd0;
            bit_cnt   <= 3'd0;
            byte_wrap <= 1'b0;
            d_orig_q  <= 1'b0;
            shift_q   <= 1'b0;
            byte_q    <= 1'b0;
            eop_q     <= 1'b0;
            align_q   <= 1'b0;
            stuff_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            dp_q      <= bus.d_plus_sync;
            prev_line <= prev_line_nxt;
            cnt       <= cnt_nxt;
            ones_cnt  <= ones_nxt;
            bit_cnt   <= bit_cnt_nxt;
            byte_wrap <= byte_wrap_nxt;
            d_orig_q  <= d_orig_nxt;
            shift_q   <= shift_nxt;
            byte_q    <= byte_wrap;
            eop_q     <= eop_nxt;
            align_q   <= align_nxt;
            stuff_q   <= stuff_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_ACTIVE;
            S_ACTIVE: begin
                if (samp) begin
                    if (se0)
                        state_nxt = S_EOP_WAIT;
                    else if ((ones_cnt == 3'd6) && bit_val)
                        state_nxt = S_ERR;
                end
            end
            S_ERR:      if (samp && se0) state_nxt = S_EOP_WAIT;
            S_EOP_WAIT: if (samp && line_j) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        // An edge only re-phases the sampler while bits are being tracked
        if (start || (((state == S_ACTIVE) || (state == S_ERR)) && line_edge))
            cnt_nxt = '0;
        else if (cnt == C_LAST_PH)
            cnt_nxt = '0;
        else
            cnt_nxt = cnt + CW'(1);
    end

    always_comb begin
        d_orig_nxt    = d_orig_q;
        shift_nxt     = 1'b0;
        eop_nxt       = 1'b0;
        align_nxt     = 1'b0;
        stuff_nxt     = 1'b0;
        byte_wrap_nxt = 1'b0;
        prev_line_nxt = prev_line;
        ones_nxt      = ones_cnt;
        bit_cnt_nxt   = bit_cnt;
        if (start) begin
            prev_line_nxt = 1'b1;
            ones_nxt      = 3'd0;
            bit_cnt_nxt   = 3'd0;
        end else if (samp && (state == S_ACTIVE)) begin
            if (se0) begin
                eop_nxt   = 1'b1;
                align_nxt = bit_cnt != 3'd0;
            end else begin
                prev_line_nxt = bus.d_plus_sync;
                if (ones_cnt == 3'd6) begin
                    if (bit_val)
                        stuff_nxt = 1'b1;
                    else
                        ones_nxt = 3'd0;
                end else begin
                    shift_nxt     = 1'b1;
                    d_orig_nxt    = bit_val;
                    ones_nxt      = bit_val ? ones_cnt + 3'd1 : 3'd0;
                    bit_cnt_nxt   = bit_cnt + 3'd1;
                    byte_wrap_nxt = bit_cnt == 3'd7;
                end
            end
        end else if (samp && (state == S_ERR) && se0) begin
            eop_nxt = 1'b1;
        end
    end

    // byte_received trails the 8th strobe so the shift register already holds the byte
    assign bus.d_orig        = d_orig_q;
    assign bus.shift_enable  = shift_q;
    assign bus.byte_received = byte_q;
    assign bus.eop           = eop_q;
    assign bus.align_err     = align_q;
    assign bus.stuff_err     = stuff_q;
endmodule
`default_nettype wire
